// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider.
// Resolves one quotient bit per clock through an IDLE -> CALC -> DONE
// sequence with a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE; the operands are captured on the
// same edge. busy is high exactly while CALC runs. done is a one-cycle pulse
// in DONE. quotient, remainder and div_by_zero are loaded together and hold
// until the next result. start seen in CALC or DONE is dropped, not queued.
//
// Optional build macro: DIVIDER_EARLY_ZERO_EN. When it is defined, a request
// with a zero divisor skips CALC and finishes in DONE straight from IDLE.
// The outputs are the same as the full-latency zero-divisor path.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Dividend shift register. It fills with quotient bits from the LSB.
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  d_reg;
    // The partial remainder only needs its low DIVISOR_W bits stored.
    // The extra bit of the (DIVISOR_W+1)-bit trial value is recreated
    // every step from the shifted-in dividend bit.
    logic [DIVISOR_W-1:0]  r_reg;
    logic [CNT_W-1:0]      cnt;

    logic                  accept;
    logic                  last_step;
    logic                  early_zero;
    logic [DIVISOR_W:0]    trial;
    logic                  trial_ge;
    logic [DIVISOR_W-1:0]  diff_low;
    logic [DIVISOR_W-1:0]  r_next;
    logic [DIVIDEND_W-1:0] q_next;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == CALC) && (cnt == LAST_STEP);

`ifdef DIVIDER_EARLY_ZERO_EN
    assign early_zero = accept && (divisor == '0);
`else
    assign early_zero = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, then subtract if it fits.
    always_comb begin
        trial    = {r_reg, q_reg[DIVIDEND_W-1]};
        trial_ge = (trial >= {1'b0, d_reg});
        // The low bits of trial - D are enough. When trial >= D the
        // difference is below D, so its top bit is always zero.
        diff_low = trial[DIVISOR_W-1:0] - d_reg;
        r_next   = trial_ge ? diff_low : trial[DIVISOR_W-1:0];
        q_next   = {q_reg[DIVIDEND_W-2:0], trial_ge};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the busy/done decodes.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = early_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one shift/subtract step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
        end else if (state == CALC) begin
            q_reg <= q_next;
            r_reg <= r_next;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers, loaded once per operation and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (last_step) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= (d_reg == '0);
        end else if (early_zero) begin
            quotient    <= '1;
            remainder   <= dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
        end
    end

endmodule
